vc_mux3_arb_ctrl: RTL and testbench
===================================

Name: vc_mux3_arb_ctrl

Overview:
- Control stage directly upstream of the 3-way select mux: arbitrates among three valid/ready requesters and drives the mux select.
- Grant is locked per multi-beat message; the lock is released on the handshaken last beat.
- Inserts scrub (idle) cycles whenever ownership passes between security domains, closing the output-channel timing leak between domains.
- Datapath is external: the mux consumes sel; this block owns all handshake and control.

Parameters:
- nscrub, 1, idle cycles inserted on a domain change between consecutive grants; 0 disables scrubbing.
- cw, $clog2(nscrub+1) (minimum 1), width of the scrub counter; derived, not overridden.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- in0_val, in1_val, in2_val  in  1 each  requester valid.
- in0_last, in1_last, in2_last  in  1 each  current beat is the final beat of the message.
- in0_dom, in1_dom, in2_dom  in  1 each  requester security domain (0 = L, 1 = H); sampled at grant.
- in0_rdy, in1_rdy, in2_rdy  out  1 each  requester ready.
- sel  out  2  mux select: 00/01/10 = input 0/1/2; 11 = no owner.
- out_val  out  1  downstream valid.
- out_last  out  1  downstream last, forwarded from the owner.
- out_rdy  in  1  downstream ready.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state = IDLE; sel = 11; all inX_rdy = 0; out_val = 0; out_last = 0.
  - Priority pointer = 2, so input 0 has highest priority first.
  - last_dom = 0; have_prev = 0; scrub counter = 0.
- States: IDLE, SCRUB, BUSY.
- IDLE:
  - sel = 11; all rdy = 0; out_val = 0.
  - If any inX_val: the round-robin winner is the first requester with val = 1, searching ptr+1, ptr+2, ptr (all mod 3). Register winner and win_dom = in<winner>_dom.
  - If have_prev && win_dom != last_dom && nscrub > 0, next state is SCRUB with counter = nscrub-1. Otherwise next state is BUSY.
  - No request: stay in IDLE.
- SCRUB:
  - sel = 11; all rdy = 0; out_val = 0.
  - Counter decrements each cycle; move to BUSY in the cycle after the counter reads 0.
  - The winner is held; requests arriving meanwhile do not re-arbitrate.
- BUSY (owner w):
  - sel = w; out_val = inW_val; out_last = inW_last; inW_rdy = out_rdy. Non-owner rdy = 0.
  - Beat transfers when inW_val && out_rdy.
  - On a transfer with inW_last = 1: next state is IDLE, ptr = w, last_dom = win_dom, have_prev = 1.
  - Owner drops val mid-message: remain locked, out_val = 0, no re-arbitration.
  - out_rdy low: hold; no state change.
- Latency:
  - From IDLE with a request, the first beat can transfer 1 cycle after the request is sampled (grant registered), or 1+nscrub cycles on a domain change.
  - Minimum gap between messages is 1 IDLE cycle.
- sel, rdy, out_val and out_last are combinational from the registered state/owner plus the live inW_val/inW_last/out_rdy. There are no combinational paths from non-owner inputs.
- Reset asserted mid-message or mid-scrub aborts immediately to reset values; the partial message is discarded.
- A single-beat message (last = 1 on the first beat) is legal.
- in_dom changing after grant is ignored until the next grant.

Decomposition:
- Shared package:
  - state encoding localparams (IDLE = 2'd0, SCRUB = 2'd1, BUSY = 2'd2).
  - SEL_NONE = 2'b11.
  - DOM_L = 1'b0, DOM_H = 1'b1.
- One sub-module: vc_rr_pick3, a combinational round-robin picker (req[2:0], ptr[1:0] -> gnt_idx[1:0], any).
  - Used only in IDLE.
  - Reusable by other 3-input arbiters.

Test Plan:
- Reset priority and single-beat transfer: all three val = 1, last = 1, same domain, out_rdy = 1 -> grants in order 0, 1, 2, 0. sel shows 00, 01, 10 in successive BUSY cycles with IDLE (sel = 11) between them.
- Multi-beat lock: in0 sends 4 beats, last on beat 4, while in1_val = 1 throughout -> sel = 00 for 4 transfers and in1_rdy = 0 throughout; in1 is granted afterwards.
- Domain scrub, nscrub = 2: in0 (dom L) message, then in1 (dom H) -> IDLE, then 2 SCRUB cycles with sel = 11 and out_val = 0, then sel = 01. Repeat with in1_dom = L -> no SCRUB cycles.
- Backpressure and bubble: out_rdy = 0 for 3 cycles, then owner val low for 2 cycles mid-message -> no transfers, owner held, out_val follows inW_val, message completes intact.
- Reset mid-message: assert reset on beat 2 of 5 -> next cycle state is IDLE, sel = 11, all rdy = 0, ptr = 2. First grant after release goes to in0.
- Boundary, nscrub = 0: alternating domains between in0 and in2 -> no scrub cycles. Idle with all val = 0 for 10 cycles -> sel stays 11 and out_val stays 0.

Source files
------------

// File: rtl/vc_mux3_arb_ctrl_pkg.sv
// Shared types and constants for the 3-way mux arbitration controller and its
// round-robin picker.
package vc_mux3_arb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCRUB = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b11;
  localparam logic       DOM_L    = 1'b0;
  localparam logic       DOM_H    = 1'b1;

  // Modulo-3 increment of a requester index; the unused code 3 wraps to 0.
  function automatic logic [1:0] rr_inc3(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/vc_mux3_arb_ctrl_if.sv
// Handshake bundle between three requesters, the arbitration controller and the
// downstream consumer of the select mux.
interface vc_mux3_arb_ctrl_if;

  logic       in0_val, in1_val, in2_val;
  logic       in0_last, in1_last, in2_last;
  logic       in0_dom, in1_dom, in2_dom;
  logic       in0_rdy, in1_rdy, in2_rdy;
  logic [1:0] sel;
  logic       out_val;
  logic       out_last;
  logic       out_rdy;

  modport master (
    output in0_val, in1_val, in2_val,
    output in0_last, in1_last, in2_last,
    output in0_dom, in1_dom, in2_dom,
    output out_rdy,
    input  in0_rdy, in1_rdy, in2_rdy,
    input  sel, out_val, out_last
  );

  modport slave (
    input  in0_val, in1_val, in2_val,
    input  in0_last, in1_last, in2_last,
    input  in0_dom, in1_dom, in2_dom,
    input  out_rdy,
    output in0_rdy, in1_rdy, in2_rdy,
    output sel, out_val, out_last
  );

endinterface

// File: rtl/vc_mux3_arb_ctrl_rr_pick3.sv
// Combinational 3-input round-robin picker: the first requester found searching
// ptr+1, ptr+2, ptr (mod 3) wins.
module vc_rr_pick3
  import vc_mux3_arb_ctrl_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_gnt_idx,
  output logic       o_any
);

  // Rotating search starting just after the last winner
  always_comb begin : p_pick
    logic [1:0] w_cand;
    o_gnt_idx = 2'd0;
    o_any     = 1'b0;
    w_cand    = rr_inc3(i_ptr);
    for (int k = 0; k < 3; k++) begin
      if (!o_any && i_req[w_cand]) begin
        o_gnt_idx = w_cand;
        o_any     = 1'b1;
      end else begin
        o_gnt_idx = o_gnt_idx;
      end
      w_cand = rr_inc3(w_cand);
    end
  end

endmodule

// File: rtl/vc_mux3_arb_ctrl.sv
// Arbitration and handshake control in front of a 3-way select mux: grants are
// locked per message and ownership changes across security domains are scrubbed.
module vc_mux3_arb_ctrl
  import vc_mux3_arb_ctrl_pkg::*;
#(
  parameter int NSCRUB = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  vc_mux3_arb_ctrl_if.slave   bus
);

  localparam int             CW         = (NSCRUB > 0) ? $clog2(NSCRUB + 1) : 1;
  localparam logic [CW-1:0]  SCRUB_LOAD = (NSCRUB > 0) ? CW'(NSCRUB - 1) : '0;

  state_e          r_state, w_state_nxt;
  logic [1:0]      r_win, w_win_nxt;
  logic            r_win_dom, w_win_dom_nxt;
  logic            r_last_dom, w_last_dom_nxt;
  logic            r_have_prev, w_have_prev_nxt;
  logic [1:0]      r_ptr, w_ptr_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  logic [2:0]      w_req;
  logic [1:0]      w_pick_idx;
  logic            w_pick_any;
  logic            w_pick_dom;
  logic            w_own_val;
  logic            w_own_last;
  logic            w_xfer;

  assign w_req = {bus.in2_val, bus.in1_val, bus.in0_val};

  vc_rr_pick3 u_pick (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .o_gnt_idx (w_pick_idx),
    .o_any     (w_pick_any)
  );

  // Domain of the requester that would win arbitration this cycle
  always_comb begin
    case (w_pick_idx)
      2'd0:    w_pick_dom = bus.in0_dom;
      2'd1:    w_pick_dom = bus.in1_dom;
      2'd2:    w_pick_dom = bus.in2_dom;
      default: w_pick_dom = DOM_L;
    endcase
  end

  // Live handshake of the registered owner only; non-owners never reach the outputs
  always_comb begin
    case (r_win)
      2'd0: begin w_own_val = bus.in0_val; w_own_last = bus.in0_last; end
      2'd1: begin w_own_val = bus.in1_val; w_own_last = bus.in1_last; end
      2'd2: begin w_own_val = bus.in2_val; w_own_last = bus.in2_last; end
      default: begin w_own_val = 1'b0; w_own_last = 1'b0; end
    endcase
  end

  assign w_xfer = (r_state == ST_BUSY) && w_own_val && bus.out_rdy;

  // Next-state logic: arbitration in IDLE, scrub countdown, lock release on last beat
  always_comb begin
    w_state_nxt     = r_state;
    w_win_nxt       = r_win;
    w_win_dom_nxt   = r_win_dom;
    w_last_dom_nxt  = r_last_dom;
    w_have_prev_nxt = r_have_prev;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_win_nxt     = w_pick_idx;
          w_win_dom_nxt = w_pick_dom;
          if (r_have_prev && (w_pick_dom != r_last_dom) && (NSCRUB > 0)) begin
            w_state_nxt = ST_SCRUB;
            w_cnt_nxt   = SCRUB_LOAD;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCRUB: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_BUSY: begin
        if (w_xfer && w_own_last) begin
          w_state_nxt     = ST_IDLE;
          w_ptr_nxt       = r_win;
          w_last_dom_nxt  = r_win_dom;
          w_have_prev_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and arbitration history registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_win       <= 2'd0;
      r_win_dom   <= DOM_L;
      r_last_dom  <= DOM_L;
      r_have_prev <= 1'b0;
      r_ptr       <= 2'd2;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_win       <= w_win_nxt;
      r_win_dom   <= w_win_dom_nxt;
      r_last_dom  <= w_last_dom_nxt;
      r_have_prev <= w_have_prev_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Mux select and handshake steering; everything is quiet outside BUSY
  always_comb begin
    bus.sel      = SEL_NONE;
    bus.out_val  = 1'b0;
    bus.out_last = 1'b0;
    bus.in0_rdy  = 1'b0;
    bus.in1_rdy  = 1'b0;
    bus.in2_rdy  = 1'b0;
    if (r_state == ST_BUSY) begin
      bus.sel      = r_win;
      bus.out_val  = w_own_val;
      bus.out_last = w_own_last;
      case (r_win)
        2'd0:    bus.in0_rdy = bus.out_rdy;
        2'd1:    bus.in1_rdy = bus.out_rdy;
        2'd2:    bus.in2_rdy = bus.out_rdy;
        default: bus.sel     = SEL_NONE;
      endcase
    end else begin
      bus.sel = SEL_NONE;
    end
  end

endmodule

// File: tb/tb_vc_mux3_arb_ctrl.sv
// Drives three controllers (scrub lengths 1, 2 and 0) with the same stimulus and
// checks each against a message-level reference model.
module tb_vc_mux3_arb_ctrl;

  logic       clk = 1'b0;
  logic       t_rst;
  logic [2:0] t_val, t_last, t_dom;
  logic       t_ordy;

  always #5 clk = ~clk;

  vc_mux3_arb_ctrl_if ifa ();
  vc_mux3_arb_ctrl_if ifb ();
  vc_mux3_arb_ctrl_if ifc ();

  assign {ifa.in2_val, ifa.in1_val, ifa.in0_val}    = t_val;
  assign {ifa.in2_last, ifa.in1_last, ifa.in0_last} = t_last;
  assign {ifa.in2_dom, ifa.in1_dom, ifa.in0_dom}    = t_dom;
  assign ifa.out_rdy = t_ordy;
  assign {ifb.in2_val, ifb.in1_val, ifb.in0_val}    = t_val;
  assign {ifb.in2_last, ifb.in1_last, ifb.in0_last} = t_last;
  assign {ifb.in2_dom, ifb.in1_dom, ifb.in0_dom}    = t_dom;
  assign ifb.out_rdy = t_ordy;
  assign {ifc.in2_val, ifc.in1_val, ifc.in0_val}    = t_val;
  assign {ifc.in2_last, ifc.in1_last, ifc.in0_last} = t_last;
  assign {ifc.in2_dom, ifc.in1_dom, ifc.in0_dom}    = t_dom;
  assign ifc.out_rdy = t_ordy;

  vc_mux3_arb_ctrl #(.NSCRUB(1)) u_dut_a (.i_clk(clk), .i_reset(t_rst), .bus(ifa));
  vc_mux3_arb_ctrl #(.NSCRUB(2)) u_dut_b (.i_clk(clk), .i_reset(t_rst), .bus(ifb));
  vc_mux3_arb_ctrl #(.NSCRUB(0)) u_dut_c (.i_clk(clk), .i_reset(t_rst), .bus(ifc));

  int checks = 0;
  int errors = 0;

  // Reference model per DUT: owner (-1 = none), cycles still to wait before the
  // owner may move data, round-robin pointer and domain history.
  int   ns[3]      = '{1, 2, 0};
  int   m_owner[3] = '{-1, -1, -1};
  int   m_wait[3]  = '{0, 0, 0};
  int   m_ptr[3]   = '{2, 2, 2};
  logic m_wdom[3]  = '{1'b0, 1'b0, 1'b0};
  logic m_ldom[3]  = '{1'b0, 1'b0, 1'b0};
  logic m_hprev[3] = '{1'b0, 1'b0, 1'b0};

  // Expected {sel, out_val, out_last, in2_rdy, in1_rdy, in0_rdy}
  function automatic logic [6:0] expv(int d);
    logic [6:0] e;
    e = 7'b1100000;
    if (m_owner[d] >= 0 && m_wait[d] == 0) begin
      e[6:5]        = 2'(m_owner[d]);
      e[4]          = t_val[m_owner[d]];
      e[3]          = t_last[m_owner[d]];
      e[m_owner[d]] = t_ordy;
    end
    return e;
  endfunction

  function automatic logic [6:0] obsv(int d);
    case (d)
      0:       return {ifa.sel, ifa.out_val, ifa.out_last, ifa.in2_rdy, ifa.in1_rdy, ifa.in0_rdy};
      1:       return {ifb.sel, ifb.out_val, ifb.out_last, ifb.in2_rdy, ifb.in1_rdy, ifb.in0_rdy};
      default: return {ifc.sel, ifc.out_val, ifc.out_last, ifc.in2_rdy, ifc.in1_rdy, ifc.in0_rdy};
    endcase
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      if (!t_rst) begin
        m_owner[d] = -1; m_wait[d] = 0; m_ptr[d] = 2; m_ldom[d] = 1'b0; m_hprev[d] = 1'b0;
      end else if (m_owner[d] < 0) begin
        for (int k = 1; k <= 3; k++) begin
          int idx;
          idx = (m_ptr[d] + k) % 3;
          if (m_owner[d] < 0 && t_val[idx]) begin
            m_owner[d] = idx;
            m_wdom[d]  = t_dom[idx];
            m_wait[d]  = (m_hprev[d] && t_dom[idx] != m_ldom[d]) ? ns[d] : 0;
          end
        end
      end else if (m_wait[d] > 0) begin
        m_wait[d] = m_wait[d] - 1;
      end else if (t_val[m_owner[d]] && t_ordy && t_last[m_owner[d]]) begin
        m_ptr[d]   = m_owner[d];
        m_ldom[d]  = m_wdom[d];
        m_hprev[d] = 1'b1;
        m_owner[d] = -1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic flush();
    t_rst = 1'b0; t_val = 3'b000; t_last = 3'b000; t_dom = 3'b000; t_ordy = 1'b1;
    tick();
    t_rst = 1'b1;
  endtask

  task automatic test_reset();
    t_rst = 1'b0; t_val = 3'b111; t_last = 3'b111; t_dom = 3'b000; t_ordy = 1'b1;
    tick(); tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obsv(d) !== 7'b1100000) begin
        $display("FAIL reset dut%0d got %b expected %b", d, obsv(d), 7'b1100000); errors++;
      end
    end
    t_rst = 1'b1;
    tick();
  endtask

  task automatic test_rr_single();
    logic [1:0] seq[4];
    logic [1:0] exp_seq[4];
    logic [6:0] o;
    int n;
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd0};
    seq = '{2'd3, 2'd3, 2'd3, 2'd3};
    n = 0;
    flush();
    t_val = 3'b111; t_last = 3'b111; t_dom = 3'b000; t_ordy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          $display("FAIL rr_model dut%0d cyc%0d got %b expected %b", d, c, obsv(d), expv(d)); errors++;
        end
      end
      o = obsv(0);
      if (o[6:5] != 2'b11 && n < 4) begin seq[n] = o[6:5]; n++; end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seq[i] !== exp_seq[i]) begin
        $display("FAIL rr_order grant%0d got %0d expected %0d", i, seq[i], exp_seq[i]); errors++;
      end
    end
  endtask

  task automatic test_lock();
    int beats, in1_hits;
    bit saw1;
    logic [6:0] o;
    beats = 0; in1_hits = 0; saw1 = 1'b0;
    flush();
    t_dom = 3'b000; t_ordy = 1'b1; t_val = 3'b001;
    for (int c = 0; c < 20 && !saw1; c++) begin
      if (c > 0) t_val = 3'b011;
      t_last = {1'b0, 1'b1, (beats == 3)};
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          $display("FAIL lock_model dut%0d cyc%0d got %b expected %b", d, c, obsv(d), expv(d)); errors++;
        end
      end
      o = obsv(0);
      if (o[6:5] == 2'd0 && o[1]) in1_hits++;
      if (o[6:5] == 2'd0 && o[4] && o[0]) beats++;
      if (o[6:5] == 2'd1) saw1 = 1'b1;
      tick();
    end
    checks++;
    if (beats != 4) begin $display("FAIL lock_beats got %0d expected 4", beats); errors++; end
    checks++;
    if (in1_hits != 0) begin $display("FAIL lock_in1_rdy got %0d expected 0", in1_hits); errors++; end
    checks++;
    if (!saw1) begin $display("FAIL lock_in1_after got 0 expected 1"); errors++; end
    t_val = 3'b000;
    tick();
  endtask

  task automatic test_scrub();
    int first1[3];
    int exp_first[3];
    logic [6:0] o;
    exp_first = '{4, 5, 3};
    first1 = '{-1, -1, -1};
    flush();
    t_ordy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      t_val  = (c < 2) ? 3'b001 : 3'b010;
      t_last = t_val;
      t_dom  = 3'b010;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          $display("FAIL scrub_model dut%0d cyc%0d got %b expected %b", d, c, obsv(d), expv(d)); errors++;
        end
        o = obsv(d);
        if (o[6:5] == 2'd1 && first1[d] < 0) first1[d] = c;
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (first1[d] != exp_first[d]) begin
        $display("FAIL scrub_gap dut%0d got %0d expected %0d", d, first1[d], exp_first[d]); errors++;
      end
    end
    first1 = '{-1, -1, -1};
    flush();
    t_val = 3'b011; t_last = 3'b011; t_dom = 3'b000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          $display("FAIL same_dom_model dut%0d cyc%0d got %b expected %b", d, c, obsv(d), expv(d)); errors++;
        end
        o = obsv(d);
        if (o[6:5] == 2'd1 && first1[d] < 0) first1[d] = c;
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (first1[d] != 3) begin
        $display("FAIL same_dom_gap dut%0d got %0d expected 3", d, first1[d]); errors++;
      end
    end
  endtask

  task automatic test_backpressure();
    int xfers, held;
    logic [6:0] o;
    xfers = 0; held = 0;
    flush();
    t_dom = 3'b000;
    for (int c = 0; c < 10; c++) begin
      t_ordy = !(c >= 1 && c <= 3);
      t_val  = (c == 4 || c == 5) ? 3'b000 : 3'b100;
      t_last = (c == 8) ? 3'b100 : 3'b000;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          $display("FAIL bp_model dut%0d cyc%0d got %b expected %b", d, c, obsv(d), expv(d)); errors++;
        end
      end
      o = obsv(1);
      if (o[6:5] == 2'd2) held++;
      if (o[6:5] == 2'd2 && o[4] && o[2]) xfers++;
      tick();
    end
    checks++;
    if (xfers != 3) begin $display("FAIL bp_xfers got %0d expected 3", xfers); errors++; end
    checks++;
    if (held != 8) begin $display("FAIL bp_held got %0d expected 8", held); errors++; end
  endtask

  task automatic test_reset_mid();
    logic [6:0] o;
    flush();
    t_val = 3'b010; t_last = 3'b000; t_dom = 3'b000; t_ordy = 1'b1;
    tick(); tick();
    t_rst = 1'b0;
    tick();
    t_rst = 1'b1; t_val = 3'b111; t_last = 3'b000;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obsv(d) !== 7'b1100000) begin
        $display("FAIL reset_mid dut%0d got %b expected %b", d, obsv(d), 7'b1100000); errors++;
      end
    end
    tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      o = obsv(d);
      checks++;
      if (o[6:5] !== 2'd0) begin
        $display("FAIL reset_regrant dut%0d got %0d expected 0", d, o[6:5]); errors++;
      end
    end
    t_last = 3'b111;
    tick();
  endtask

  task automatic test_idle_nscrub0();
    int idle_c;
    logic [6:0] o;
    idle_c = 0;
    flush();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        o = obsv(d);
        checks++;
        if (o[6:5] !== 2'b11 || o[4] !== 1'b0) begin
          $display("FAIL idle dut%0d cyc%0d got sel %0d val %b expected sel 3 val 0", d, c, o[6:5], o[4]); errors++;
        end
      end
      tick();
    end
    t_val = 3'b101; t_last = 3'b101; t_dom = 3'b100;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          $display("FAIL alt_dom_model dut%0d cyc%0d got %b expected %b", d, c, obsv(d), expv(d)); errors++;
        end
      end
      o = obsv(2);
      if (o[6:5] == 2'b11) idle_c++;
      tick();
    end
    checks++;
    if (idle_c != 6) begin $display("FAIL nscrub0_idle got %0d expected 6", idle_c); errors++; end
  endtask

  task automatic test_random();
    flush();
    for (int c = 0; c < 600; c++) begin
      t_rst  = ($urandom_range(0, 80) != 0);
      t_val  = 3'($urandom);
      t_last = 3'($urandom) & 3'($urandom);
      t_dom  = 3'($urandom);
      t_ordy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          $display("FAIL random dut%0d cyc%0d got %b expected %b", d, c, obsv(d), expv(d)); errors++;
        end
      end
      tick();
    end
  endtask

  initial begin
    t_rst = 1'b0; t_val = 3'b000; t_last = 3'b000; t_dom = 3'b000; t_ordy = 1'b0;
    test_reset();
    test_rr_single();
    test_lock();
    test_scrub();
    test_backpressure();
    test_reset_mid();
    test_idle_nscrub0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
